// File: rtl/seven_segment_capture.sv
// seven_segment_capture: samples multiplexed an/seg pins, glitch-filters them and decodes each digit
//   clk, rst_n          clock, asynchronous active-low reset
//   an, seg             active-low anodes and active-high segments {g,f,e,d,c,b,a}, asynchronous
//   clr                 synchronous clear of digit_valid/digit_err
//   digit_code          decoded 4-bit code per digit, digit i at [4*i+3:4*i]
//   digit_valid         digit captured since reset/clr
//   digit_err           last accepted pattern of the digit was not a known glyph
//   upd, upd_idx        one-cycle pulse and index when a digit's stored value changed
module seven_segment_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  input  logic                    clr,
  output logic [4*NUM_DIGITS-1:0] digit_code,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    upd,
  output logic [2:0]              upd_idx
);
  localparam int W  = NUM_DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, FILTER, HELD} state_t;
  state_t          st;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    m, s, s_d;
  logic [NUM_DIGITS-1:0] s_an;
  logic            addr, start, drop, adv, done, cmt;
  logic [2:0]      idx, cmt_idx;
  logic [4:0]      dec, cmt_dec;
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b0000110: decode = 5'b0_1001;
      7'b1011011: decode = 5'b0_1010;
      7'b1001111: decode = 5'b0_1011;
      7'b1100110: decode = 5'b0_1100;
      7'b1101101: decode = 5'b0_1101;
      7'b1111101: decode = 5'b0_1110;
      7'b0000111: decode = 5'b0_1111;
      7'b1111111: decode = 5'b0_1000;
      7'b0000000: decode = 5'b0_0000;
      default:    decode = 5'b1_0000;
    endcase
  endfunction
  // start: a fresh addressable value begins a stable run; drop: bus went idle/conflicting
  always_comb begin
    s_an = s[W-1:7];
    addr = $onehot(~s_an);
    idx = '0;
    for (int j = 0; j < NUM_DIGITS; j++) idx = s_an[j] ? idx : 3'(j);
    dec = decode(s[6:0]);
    start = (st == IDLE || s != s_d) && addr;
    drop = st != IDLE && s != s_d && !addr;
    adv = st == FILTER && s == s_d;
    done = start ? STABLE_CYCLES == 1 : adv && int'(cnt) + 1 == STABLE_CYCLES;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '0;
      s <= '0;
      s_d <= '0;
      st <= IDLE;
      cnt <= '0;
      cmt <= 1'b0;
      cmt_idx <= '0;
      cmt_dec <= '0;
      digit_code <= '0;
      digit_valid <= '0;
      digit_err <= '0;
      upd <= 1'b0;
      upd_idx <= '0;
    end else begin
      m <= {an, seg};
      s <= m;
      s_d <= s;
      st <= done ? HELD : start ? FILTER : drop ? IDLE : st;
      cnt <= start ? CW'(1) : drop ? '0 : adv ? cnt + 1'b1 : cnt;
      cmt <= done;
      cmt_idx <= idx;
      cmt_dec <= dec;
      upd <= 1'b0;
      if (clr) begin
        digit_valid <= '0;
        digit_err <= '0;
      end else if (cmt) begin
        for (int j = 0; j < NUM_DIGITS; j++) begin
          if (3'(j) == cmt_idx) begin
            digit_code[4*j +: 4] <= cmt_dec[3:0];
            digit_valid[j] <= 1'b1;
            digit_err[j] <= cmt_dec[4];
            upd <= !digit_valid[j] || digit_code[4*j +: 4] != cmt_dec[3:0] || digit_err[j] != cmt_dec[4];
            upd_idx <= cmt_idx;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_seven_segment_capture.sv
// tb_seven_segment_capture: randomized and directed checks of seven_segment_capture against a run-length model
module tb_seven_segment_capture;
  localparam int N = 4, S = 4;
  logic clk = 0, rst_n = 1, clr = 0;
  logic [N-1:0] an = '1;
  logic [6:0] seg = '0;
  logic [4*N-1:0] digit_code;
  logic [N-1:0] digit_valid, digit_err;
  logic upd;
  logic [2:0] upd_idx;
  int errors = 0, checks = 0;
  logic [6:0] pat [9] = '{7'b0000000, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                          7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111};
  logic [3:0] val [9] = '{4'h0, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h8};
  always #5 clk = ~clk;
  seven_segment_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .clr(clr),
    .digit_code(digit_code), .digit_valid(digit_valid), .digit_err(digit_err),
    .upd(upd), .upd_idx(upd_idx)
  );
  typedef struct packed {logic v; logic [2:0] idx; logic [3:0] code; logic err;} ev_t;
  ev_t pipe [3];
  ev_t ev;
  logic [N+6:0] prev;
  int run;
  logic [4*N-1:0] e_code;
  logic [N-1:0] e_valid, e_err;
  logic e_upd;
  logic [2:0] e_idx;
  // a pin value held for S consecutive samples is accepted; it shows on the outputs 3 edges later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_code = '0; e_valid = '0; e_err = '0; e_upd = 0; e_idx = '0;
      prev = '0; run = 0;
      for (int j = 0; j < 3; j++) pipe[j] = '0;
    end else begin
      ev = pipe[2]; pipe[2] = pipe[1]; pipe[1] = pipe[0];
      run = ({an, seg} == prev) ? run + 1 : 1;
      prev = {an, seg};
      pipe[0] = '0;
      pipe[0].v = run == S && $countones(~an) == 1;
      for (int j = 0; j < N; j++) if (!an[j]) pipe[0].idx = 3'(j);
      pipe[0].err = 1;
      for (int i = 0; i < 9; i++) if (seg == pat[i]) begin pipe[0].code = val[i]; pipe[0].err = 0; end
      e_upd = 0;
      if (clr) begin
        e_valid = '0; e_err = '0;
      end else if (ev.v) begin
        e_upd = !e_valid[ev.idx] || e_code[4*ev.idx +: 4] != ev.code || e_err[ev.idx] != ev.err;
        e_code[4*ev.idx +: 4] = ev.code;
        e_valid[ev.idx] = 1;
        e_err[ev.idx] = ev.err;
        e_idx = ev.idx;
      end
    end
  end
  task automatic cyc(input logic [N-1:0] a, input logic [6:0] sg, input logic c);
    an = a; seg = sg; clr = c;
    @(posedge clk); #1;
  endtask
  task automatic test_reset_state;
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({digit_code, digit_valid, digit_err, upd, upd_idx} !== '0) begin
      errors++;
      $display("FAIL reset_state got %h/%b/%b/%b/%0d want all zero", digit_code, digit_valid, digit_err, upd, upd_idx);
    end
    rst_n = 1;
  endtask
  task automatic test_single;
    repeat (4) cyc('1, 7'b0, 0);
    for (int c = 0; c < 10; c++) begin
      cyc(4'b1110, 7'b1011011, 0);
      checks++;
      if (upd !== (c == 6)) begin errors++; $display("FAIL single_upd_timing edge=%0d upd=%b want %b", c, upd, c == 6); end
      if (c == 6) begin
        checks++;
        if (upd_idx !== 3'd0) begin errors++; $display("FAIL single_upd_idx got %0d want 0", upd_idx); end
      end
    end
    checks++;
    if (digit_code[3:0] !== 4'hA || digit_valid !== 4'b0001) begin
      errors++; $display("FAIL single_value code=%h valid=%b want a/0001", digit_code[3:0], digit_valid);
    end
  endtask
  task automatic test_short;
    int seen = 0;
    repeat (3) begin cyc(4'b1011, 7'b0000110, 0); seen += upd; end
    repeat (8) begin cyc('1, 7'b0, 0); seen += upd; end
    checks++;
    if (seen != 0 || digit_valid[2] !== 1'b0) begin
      errors++; $display("FAIL short_no_commit upds=%0d valid=%b want 0/x0xx", seen, digit_valid);
    end
    repeat (8) begin cyc(4'b1011, 7'b0000110, 0); seen += upd; end
    checks++;
    if (seen != 1 || digit_code[11:8] !== 4'h9 || digit_valid !== 4'b0101) begin
      errors++; $display("FAIL short_commit upds=%0d code=%h valid=%b want 1/9/0101", seen, digit_code[11:8], digit_valid);
    end
  endtask
  task automatic test_same;
    int seen = 0;
    repeat (5) cyc('1, 7'b0, 0);
    repeat (10) begin cyc(4'b1110, 7'b1011011, 0); seen += upd; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL same_no_upd upds=%0d want 0", seen); end
    for (int c = 0; c < 10; c++) begin
      cyc(4'b1110, 7'b1111111, 0);
      seen += upd;
      if (upd) begin
        checks++;
        if (upd_idx !== 3'd0) begin errors++; $display("FAIL same_upd_idx got %0d want 0", upd_idx); end
      end
    end
    checks++;
    if (seen != 1 || digit_code[3:0] !== 4'h8) begin
      errors++; $display("FAIL same_change upds=%0d code=%h want 1/8", seen, digit_code[3:0]);
    end
  endtask
  task automatic test_err;
    int seen = 0;
    logic [4*N+2*N-1:0] snap;
    repeat (10) begin cyc(4'b0111, 7'b0101010, 0); seen += upd; end
    checks++;
    if (seen != 1 || digit_err !== 4'b1000 || digit_code[15:12] !== 4'h0 || digit_valid !== 4'b1101) begin
      errors++; $display("FAIL err_commit upds=%0d err=%b code=%h valid=%b want 1/1000/0/1101", seen, digit_err, digit_code[15:12], digit_valid);
    end
    snap = {digit_code, digit_valid, digit_err};
    seen = 0;
    repeat (20) begin cyc(4'b0011, 7'($urandom), 0); seen += upd; end
    repeat (20) begin cyc(4'b1111, 7'($urandom), 0); seen += upd; end
    checks++;
    if (seen != 0 || {digit_code, digit_valid, digit_err} !== snap) begin
      errors++; $display("FAIL err_unaddressable upds=%0d state=%h want 0/%h", seen, {digit_code, digit_valid, digit_err}, snap);
    end
  endtask
  task automatic test_scan;
    for (int r = 0; r < 2; r++)
      for (int d = 0; d < 4; d++)
        repeat (8) cyc(~(4'b1 << d), pat[d+1], 0);
    checks++;
    if (digit_code !== 16'hCBA9 || digit_valid !== 4'b1111 || digit_err !== 4'b0000) begin
      errors++; $display("FAIL scan codes=%h valid=%b err=%b want cba9/1111/0000", digit_code, digit_valid, digit_err);
    end
    cyc(4'b0111, pat[4], 1);
    checks++;
    if (digit_code !== 16'hCBA9 || digit_valid !== 4'b0000 || digit_err !== 4'b0000 || upd !== 1'b0) begin
      errors++; $display("FAIL scan_clr codes=%h valid=%b err=%b upd=%b want cba9/0000/0000/0", digit_code, digit_valid, digit_err, upd);
    end
    repeat (8) cyc(4'b0111, pat[4], 0);
    checks++;
    if (digit_valid !== 4'b0000) begin errors++; $display("FAIL scan_no_recapture valid=%b want 0000", digit_valid); end
  endtask
  task automatic test_clr_collide;
    int seen = 0;
    for (int c = 0; c < 10; c++) begin cyc(4'b1101, pat[5], c == 6); seen += upd; end
    checks++;
    if (seen != 0 || digit_valid !== 4'b0000 || digit_code[7:4] !== 4'hA) begin
      errors++; $display("FAIL clr_collide upds=%0d valid=%b code=%h want 0/0000/a", seen, digit_valid, digit_code[7:4]);
    end
    repeat (8) cyc(4'b1101, pat[6], 0);
    checks++;
    if (digit_valid !== 4'b0010 || digit_code[7:4] !== 4'hE) begin
      errors++; $display("FAIL clr_recapture valid=%b code=%h want 0010/e", digit_valid, digit_code[7:4]);
    end
  endtask
  task automatic test_random;
    logic [N-1:0] a;
    logic [6:0] sg;
    int k, d1, d2;
    for (int t = 0; t < 150; t++) begin
      k = $urandom_range(0, 9);
      d1 = $urandom_range(0, N-1);
      d2 = (d1 + 1 + $urandom_range(0, N-2)) % N;
      a = (k == 0) ? '1 : (k == 1) ? ~((4'b1 << d1) | (4'b1 << d2)) : ~(4'b1 << d1);
      sg = ($urandom_range(0, 3) == 0) ? 7'($urandom) : pat[$urandom_range(0, 8)];
      repeat ($urandom_range(1, 8)) begin
        cyc(a, sg, $urandom_range(0, 31) == 0);
        checks++;
        if ({digit_code, digit_valid, digit_err, upd} !== {e_code, e_valid, e_err, e_upd} || (upd && upd_idx !== e_idx)) begin
          errors++;
          $display("FAIL random t=%0d got %h/%b/%b/%b/%0d want %h/%b/%b/%b/%0d", t, digit_code, digit_valid, digit_err, upd, upd_idx,
                   e_code, e_valid, e_err, e_upd, e_idx);
        end
      end
    end
  endtask
  task automatic test_reset;
    repeat (3) cyc(4'b1110, pat[1], 0);
    repeat (2) cyc(4'b1110, pat[3], 0);
    #3 rst_n = 0;
    #1;
    checks++;
    if ({digit_code, digit_valid, digit_err, upd, upd_idx} !== '0) begin
      errors++; $display("FAIL reset_async got %h/%b/%b/%b/%0d want all zero", digit_code, digit_valid, digit_err, upd, upd_idx);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    for (int c = 0; c < 10; c++) begin
      cyc(4'b1110, pat[3], 0);
      checks++;
      if ({digit_code, digit_valid, digit_err, upd} !== {e_code, e_valid, e_err, e_upd}) begin
        errors++; $display("FAIL reset_recover c=%0d got %h/%b/%b/%b want %h/%b/%b/%b", c, digit_code, digit_valid, digit_err, upd,
                           e_code, e_valid, e_err, e_upd);
      end
    end
    checks++;
    if (digit_valid !== 4'b0001 || digit_code !== 16'h000B) begin
      errors++; $display("FAIL reset_recapture valid=%b code=%h want 0001/000b", digit_valid, digit_code);
    end
  endtask
  initial begin
    test_reset_state;
    test_single;
    test_short;
    test_same;
    test_err;
    test_scan;
    test_clr_collide;
    test_random;
    test_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
